multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back. It drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU-control decoder (00 = add, 01 = subtract, 10 = decode Funct). Memory accesses use a ready handshake with an optional timeout.

Parameters:
MAX_WAIT, 0, max consecutive not-ready cycles in a memory wait state before abort; 0 = wait forever
WAIT_W, 8, width of the wait counter; MAX_WAIT must be < 2**WAIT_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
Op  input  6  opcode from instruction register, stable from DECODE onward
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  write-back data select: 1 = MDR
IRWrite  output  1  instruction register load
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
ALUOp  output  2  to ALU control
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
RegWrite  output  1  register file write
RegDst  output  1  1 = rd, 0 = rt
State  output  4  current state, for debug
Illegal  output  1  one-cycle pulse: unrecognised opcode
Timeout  output  1  one-cycle pulse: memory wait aborted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- While reset=1: all control outputs 0, Illegal=0, Timeout=0. State register loads FETCH (0) at the edge; wait counter cleared. Reset mid-instruction aborts it with no further writes.
- Outputs are Moore, decoded from State only, except IRWrite/PCWrite in FETCH, which are gated by MemReady. Any signal not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12-15 go to FETCH.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=MemReady.
  - Transition: to DECODE when MemReady, else hold.
- DECODE:
  - Outputs: ALUSrcB=11, ALUOp=00.
  - Transition on Op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; otherwise Illegal=1 and -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- Cycle counts with MemReady=1 throughout: R-type 4, lw 5, sw 4, beq 3, j 3.
- Wait counter:
  - Counts consecutive MemReady=0 cycles in FETCH, MEMRD and MEMWR; cleared on any state change or when MemReady=1.
  - If MAX_WAIT>0 and the count reaches MAX_WAIT-1 with MemReady=0, then Timeout=1 that cycle. Next state is FETCH; from FETCH itself this means a retry with the counter cleared.
  - MemReady=1 in the timeout cycle takes priority: normal advance, no Timeout.
- Illegal and Timeout are never asserted together.

Optional Feature:
ADDI_EN.
- Defined: Op=001000 in DECODE goes to ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00), then ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0), then FETCH. addi takes 4 cycles.
- Undefined: 001000 is Illegal and states 10/11 are unreachable (they decode to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - the ALUOp encodings (ALUOP_ADD/SUB/FUNCT) shared with the ALU-control decoder;
  - the state enumeration;
  - the PCSource and ALUSrcB select constants.
- One sub-module: mem_wait_timer (counter, MemReady, MAX_WAIT compare -> expire).

Test Plan:
- reset high 3 cycles, Op=000000, MemReady=1 -> all outputs 0 during reset; State sequence 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=RegDst=1 in ALUWB.
- Op=100011, MemReady low for 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0; MemRead=IorD=1 throughout MEMRD; MemtoReg=RegWrite=1 in MEMWB.
- Op=000100 -> State 0,1,8,0; in BRANCH ALUOp=01, PCWriteCond=1, PCSource=01, PCWrite=0.
- Op=111111 -> Illegal=1 for exactly one cycle in DECODE, then FETCH; with ADDI_EN undefined Op=001000 behaves the same; with ADDI_EN defined -> 0,1,10,11,0.
- MAX_WAIT=4, Op=101011, MemReady=0 in MEMWR -> Timeout=1 on 4th MEMWR cycle, State=0 next, MemWrite=0.
- reset asserted during EXEC -> next cycle all outputs 0; after release State=0 with MemRead=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes,
// ALUOp codes used by the ALU-control decoder, mux selects and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    // Bundle of every datapath control signal, so one default clears them all.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // States that wait on the memory ready handshake.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles in a memory wait state
// and flags expiry on the MAX_WAIT-th one. MAX_WAIT = 0 disables expiry.
module mem_wait_timer #(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    input  logic clear,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LIMIT = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

    logic [WAIT_W-1:0] count;

    // Count stalled cycles; any progress, state change or abort restarts it.
    always_ff @(posedge clk) begin
        if (reset || !active || mem_ready || clear || expire)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    // Expire on the last permitted stall; a ready memory always wins.
    always_comb begin
        expire = (MAX_WAIT > 0) && active && !mem_ready && (count == LIMIT);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS datapath.
// Optional macro ADDI_EN adds the addi path (ADDIEX/ADDIWB states).
// Handshake: MemReady high in FETCH/MEMRD/MEMWR completes the access that
// cycle; while low the FSM holds, and with MAX_WAIT > 0 it aborts to FETCH
// after MAX_WAIT consecutive not-ready cycles, pulsing Timeout.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] State,
    output logic       Illegal,
    output logic       Timeout
);

    state_t state, next_state;
    ctrl_t  ctrl, ctrl_out;
    logic   illegal;
    logic   expire;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .active    (is_mem_wait(state)),
        .mem_ready (MemReady),
        .clear     (next_state != state),
        .expire    (expire)
    );

    // State register; reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state and Moore control decode (FETCH enables gated by MemReady).
    always_comb begin
        ctrl       = '0;
        next_state = state;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
                if (MemReady)    next_state = S_MEMWB;
                else if (expire) next_state = S_FETCH;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                if (MemReady || expire) next_state = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                next_state     = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                next_state         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                next_state     = S_FETCH;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                next_state     = S_FETCH;
            end
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // Reset forces every control output low so an aborted instruction writes nothing.
    always_comb begin
        ctrl_out    = reset ? '0 : ctrl;
        PCWrite     = ctrl_out.pc_write;
        PCWriteCond = ctrl_out.pc_write_cond;
        IorD        = ctrl_out.ior_d;
        MemRead     = ctrl_out.mem_read;
        MemWrite    = ctrl_out.mem_write;
        MemtoReg    = ctrl_out.mem_to_reg;
        IRWrite     = ctrl_out.ir_write;
        PCSource    = ctrl_out.pc_source;
        ALUOp       = ctrl_out.alu_op;
        ALUSrcA     = ctrl_out.alu_src_a;
        ALUSrcB     = ctrl_out.alu_src_b;
        RegWrite    = ctrl_out.reg_write;
        RegDst      = ctrl_out.reg_dst;
        State       = state;
        Illegal     = illegal && !reset;
        Timeout     = expire && !reset;
    end

endmodule
